mem_burst_ctrl: RTL and testbench

Burst access sequencer sitting directly upstream of the 8x8 synchronous memory (3-bit address, 8-bit data, single `enable`, `rb_w` = 1 write / 0 read, registered read data with one-cycle latency). It accepts a command (direction, base address, beat count) over a valid/ready handshake. It then drives the memory's `enable`/`rb_w`/`address`/`data_in` pins to perform 1–8 consecutive accesses with wrap-around addressing. Write data arrives on a valid/ready stream; read data is returned on a valid-only stream taken straight from the memory's `data_out`.

---
 rtl/mem_burst_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_burst_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of an 8x8 synchronous memory: runs 1-8 wrapping
// write or read accesses per command and streams read data straight back.
module mem_burst_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_write,
    input  logic [2:0] i_cmd_addr,
    input  logic [2:0] i_cmd_len,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [7:0] i_wr_data,
    output logic       o_rd_valid,
    output logic [7:0] o_rd_data,
    output logic       o_rd_last,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_mem_enable,
    output logic       o_mem_rb_w,
    output logic [2:0] o_mem_address,
    output logic [7:0] o_mem_data_in,
    input  logic [7:0] i_mem_data_out
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } state_e;

    state_e     r_state;
    logic [2:0] r_base;
    logic [2:0] r_len;
    logic [2:0] r_cnt;
    logic       r_rd_valid;
    logic       r_rd_last;
    logic       r_done;

    logic [2:0] w_beat_addr;
    logic       w_last_beat;

    // 3-bit sum wraps naturally from 7 back to 0
    assign w_beat_addr = r_base + r_cnt;
    assign w_last_beat = (r_cnt == r_len);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_base     <= 3'd0;
            r_len      <= 3'd0;
            r_cnt      <= 3'd0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Memory read data lags its address by one cycle, so the return
            // qualifiers are delayed copies of the issue state.
            r_rd_valid <= (r_state == StRead);
            r_rd_last  <= (r_state == StRead) && w_last_beat;
            r_done     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_base  <= i_cmd_addr;
                        r_len   <= i_cmd_len;
                        r_cnt   <= 3'd0;
                        r_state <= i_cmd_write ? StWrite : StRead;
                    end
                end
                StWrite: begin
                    if (i_wr_valid) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last_beat) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last_beat) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_cmd_ready   = 1'b0;
        o_wr_ready    = 1'b0;
        o_mem_enable  = 1'b0;
        o_mem_rb_w    = 1'b0;
        o_mem_address = r_base;
        o_mem_data_in = 8'h00;
        case (r_state)
            StIdle: begin
                o_cmd_ready = 1'b1;
            end
            StWrite: begin
                o_wr_ready    = 1'b1;
                o_mem_enable  = i_wr_valid;
                o_mem_rb_w    = 1'b1;
                o_mem_address = w_beat_addr;
                o_mem_data_in = i_wr_data;
            end
            StRead: begin
                o_mem_enable  = 1'b1;
                o_mem_address = w_beat_addr;
            end
            default: ;
        endcase
    end

    assign o_busy     = (r_state != StIdle);
    assign o_rd_valid = r_rd_valid;
    assign o_rd_last  = r_rd_last;
    assign o_done     = r_done;
    assign o_rd_data  = i_mem_data_out;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural 8x8 synchronous memory
// attached to its memory pins.
module tb_mem_burst_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [2:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       done;
    logic       busy;
    logic       mem_enable;
    logic       mem_rb_w;
    logic [2:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    logic [7:0] mem [8] = '{default: 8'h00};

    int checks   = 0;
    int failures = 0;

    mem_burst_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_write    (cmd_write),
        .i_cmd_addr     (cmd_addr),
        .i_cmd_len      (cmd_len),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_data      (wr_data),
        .o_rd_valid     (rd_valid),
        .o_rd_data      (rd_data),
        .o_rd_last      (rd_last),
        .o_done         (done),
        .o_busy         (busy),
        .o_mem_enable   (mem_enable),
        .o_mem_rb_w     (mem_rb_w),
        .o_mem_address  (mem_address),
        .o_mem_data_in  (mem_data_in),
        .i_mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: write or registered read on enable, one-cycle read latency
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_rb_w) mem[mem_address] <= mem_data_in;
            else          mem_data_out     <= mem[mem_address];
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [2:0] base, input logic [2:0] len,
                               input logic [63:0] data, input logic [7:0] gaps);
        logic [2:0] a;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = base; cmd_len = len;
        #1 check("wr_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (gaps[k]) begin
                wr_valid = 1'b0;
                #1 check("wr_gap_enable", mem_enable, 1'b0);
                check("wr_gap_ready", wr_ready, 1'b1);
                @(negedge clk);
            end
            a = base + 3'(k);
            wr_valid = 1'b1;
            wr_data  = data[8*k +: 8];
            #1 check("wr_enable", mem_enable, 1'b1);
            check("wr_rb_w", mem_rb_w, 1'b1);
            check("wr_addr", {5'd0, mem_address}, {5'd0, a});
            check("wr_data_in", mem_data_in, data[8*k +: 8]);
            check("wr_busy_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1 check("wr_done", done, 1'b1);
        check("wr_end_busy", busy, 1'b0);
        check("wr_end_cmd_ready", cmd_ready, 1'b1);
    endtask

    // preloaded: command already on the bus and accepted at the coming edge
    task automatic read_burst(input logic [2:0] base, input logic [2:0] len,
                              input logic [63:0] exp, input bit preloaded);
        logic [2:0] a;
        if (!preloaded) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = base; cmd_len = len;
            #1 check("rd_cmd_ready", cmd_ready, 1'b1);
        end
        for (int k = 0; k <= int'(len) + 1; k++) begin
            @(negedge clk);
            if (k == 0) cmd_valid = 1'b0;
            #1;
            if (k <= int'(len)) begin
                a = base + 3'(k);
                check("rd_enable", mem_enable, 1'b1);
                check("rd_rb_w", mem_rb_w, 1'b0);
                check("rd_addr", {5'd0, mem_address}, {5'd0, a});
            end
            if (k == 0) begin
                check("rd_valid_first", rd_valid, 1'b0);
            end else begin
                check("rd_valid", rd_valid, 1'b1);
                check("rd_data", rd_data, exp[8*(k-1) +: 8]);
                check("rd_last", rd_last, (k == int'(len) + 1) ? 1'b1 : 1'b0);
                check("rd_done", done, (k == int'(len) + 1) ? 1'b1 : 1'b0);
            end
        end
        check("rd_end_busy", busy, 1'b0);
        check("rd_end_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_len = 3'd0;
        wr_valid = 1'b0; wr_data = 8'h00;
        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_enable", mem_enable, 1'b0);
        check("rst_addr", {5'd0, mem_address}, 8'h00);
        check("rst_rd_valid", rd_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four beats at 2..5 with idle gaps before beats 0, 1 and 3
        write_burst(3'd2, 3'd3, 64'h0000_0000_4433_2211, 8'b0000_1011);
        check("mem2", mem[2], 8'h11);
        check("mem5", mem[5], 8'h44);
        check("mem1_untouched", mem[1], 8'h00);
        check("mem6_untouched", mem[6], 8'h00);
        @(negedge clk);
        #1 check("wr_done_pulse_end", done, 1'b0);

        read_burst(3'd2, 3'd3, 64'h0000_0000_4433_2211, 1'b0);

        // Wrap: 6,7,0..5 receive A0..A7
        write_burst(3'd6, 3'd7, 64'hA7A6_A5A4_A3A2_A1A0, 8'h00);
        check("mem0_wrap", mem[0], 8'hA2);
        read_burst(3'd6, 3'd7, 64'hA7A6_A5A4_A3A2_A1A0, 1'b0);

        // Back-to-back single-beat reads with cmd_valid held
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd5; cmd_len = 3'd0;
        #1 check("b2b_ready1", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_addr = 3'd0;
        #1 check("b2b_busy_ready", cmd_ready, 1'b0);
        check("b2b_addr1", {5'd0, mem_address}, 8'd5);
        @(negedge clk);
        #1 check("b2b_rd_valid1", rd_valid, 1'b1);
        check("b2b_rd_data1", rd_data, 8'hA7);
        check("b2b_done1", done, 1'b1);
        check("b2b_ready2", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 check("b2b_addr2", {5'd0, mem_address}, 8'd0);
        check("b2b_enable2", mem_enable, 1'b1);
        check("b2b_rd_valid_gap", rd_valid, 1'b0);
        @(negedge clk);
        #1 check("b2b_rd_valid2", rd_valid, 1'b1);
        check("b2b_rd_data2", rd_data, 8'hA2);
        check("b2b_last2", rd_last, 1'b1);

        // Command held while a write runs: ignored until IDLE, base kept
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd4; cmd_len = 3'd1;
        #1 check("busy_ready0", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 3'd7; cmd_len = 3'd5;
        wr_valid = 1'b1; wr_data = 8'h55;
        #1 check("busy_ready1", cmd_ready, 1'b0);
        check("busy_addr1", {5'd0, mem_address}, 8'd4);
        @(negedge clk);
        wr_data = 8'h66;
        #1 check("busy_ready2", cmd_ready, 1'b0);
        check("busy_addr2", {5'd0, mem_address}, 8'd5);
        @(negedge clk);
        wr_valid = 1'b0;
        #1 check("busy_done", done, 1'b1);
        check("busy_ready_idle", cmd_ready, 1'b1);
        read_burst(3'd7, 3'd5, 64'h0000_55A5_A4A3_A2A1, 1'b1);

        // Asynchronous reset in the middle of a read burst
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_len = 3'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("mid_rd_valid", rd_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("arst_busy", busy, 1'b0);
        check("arst_cmd_ready", cmd_ready, 1'b1);
        check("arst_wr_ready", wr_ready, 1'b0);
        check("arst_enable", mem_enable, 1'b0);
        check("arst_rb_w", mem_rb_w, 1'b0);
        check("arst_addr", {5'd0, mem_address}, 8'd0);
        check("arst_data_in", mem_data_in, 8'h00);
        check("arst_rd_valid", rd_valid, 1'b0);
        check("arst_rd_last", rd_last, 1'b0);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_rd_valid", rd_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
